spi_master: RTL and testbench



---
 rtl/spi_master.sv | 146 ++++++++++++++
 tb/tb_spi_master.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 (CPOL=0, CPHA=0), MSB-first, full-duplex frame initiator.
//
// A single start request shifts one FRAME_BITS word out on mosi and captures
// the same number of bits from miso. sck runs at clk/(2*CLK_DIV).
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   start    in   frame request, honoured only while idle
//   tx_data  in   word to transmit, captured when start is accepted
//   busy     out  frame in progress (cycle after acceptance until completion)
//   done     out  one-cycle completion pulse; rx_data is valid from this cycle
//   rx_data  out  last completed received word
//   sck      out  SPI clock, idles low
//   cs_n     out  chip select, active low, idles high
//   mosi     out  serial data out, changes on sck fall
//   miso     in   serial data in, sampled on sck rise
module spi_master #(
  parameter int FRAME_BITS = 32,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  sck,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int CNT_W = $clog2(FRAME_BITS) + 1;

  localparam logic [DIV_W-1:0] PHASE_END = DIV_W'(CLK_DIV - 1);
  // HOLD covers a trailing sck-low half-period plus the chip-select hold, so
  // cs_n stays low for (2*FRAME_BITS+2)*CLK_DIV cycles in total.
  localparam logic [DIV_W-1:0] HOLD_END  = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HI,
    SCK_LO,
    HOLD
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DIV_W-1:0]      div_cnt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [FRAME_BITS-1:0] rx_shift;
  logic                  phase_done;

  assign phase_done = (div_cnt == ((state == HOLD) ? HOLD_END : PHASE_END));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all registers update
    // from the same pre-edge values, independent of statement order.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaulting state_next before the case keeps this block purely
    // combinational; a path that leaves it unassigned would infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (start)      state_next = SETUP;
      SETUP:   if (phase_done) state_next = SCK_HI;
      SCK_HI:  if (phase_done) state_next = (bit_cnt == LAST_BIT) ? HOLD : SCK_LO;
      SCK_LO:  if (phase_done) state_next = SCK_HI;
      HOLD:    if (phase_done) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    sck  = 1'b0;
    cs_n = 1'b1;
    busy = 1'b0;
    mosi = tx_shift[FRAME_BITS-1];
    if (state != IDLE) begin
      cs_n = 1'b0;
      busy = 1'b1;
    end
    if (state == SCK_HI) begin
      sck = 1'b1;
    end
  end

  // Datapath: divider, bit counter, shift registers, completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;

      // Each state's dwell is timed from zero on entry.
      if (state == IDLE || state_next != state) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (state == IDLE && start) begin
        tx_shift <= tx_data;
        rx_shift <= '0;
        bit_cnt  <= '0;
      end

      // The edge that raises sck is the sampling instant for miso.
      if (state != SCK_HI && state_next == SCK_HI) begin
        rx_shift <= {rx_shift[FRAME_BITS-2:0], miso};
      end

      // The edge that drops sck presents the next mosi bit.
      if (state == SCK_HI && state_next == SCK_LO) begin
        tx_shift <= tx_shift << 1;
        bit_cnt  <= bit_cnt + CNT_W'(1);
      end

      if (state == HOLD && state_next == IDLE) begin
        done    <= 1'b1;
        rx_data <= rx_shift;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed + randomized bench for spi_master.
// Instantiates a 32-bit/CLK_DIV=4 master (loopback or behavioural slave on
// miso) and a 16-bit/CLK_DIV=1 master in loopback.
module tb_spi_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] tx_data;
  logic        busy;
  logic        done;
  logic [31:0] rx_data;
  logic        sck;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        loop;

  logic        start16;
  logic [15:0] tx16;
  logic        busy16;
  logic        done16;
  logic [15:0] rx16;
  logic        sck16;
  logic        cs16;
  logic        mosi16;

  always #5 clk = ~clk;

  spi_master #(.FRAME_BITS(32), .CLK_DIV(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .tx_data (tx_data),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .sck     (sck),
    .cs_n    (cs_n),
    .mosi    (mosi),
    .miso    (miso)
  );

  spi_master #(.FRAME_BITS(16), .CLK_DIV(1)) dut16 (
    .clk     (clk),
    .reset   (reset),
    .start   (start16),
    .tx_data (tx16),
    .busy    (busy16),
    .done    (done16),
    .rx_data (rx16),
    .sck     (sck16),
    .cs_n    (cs16),
    .mosi    (mosi16),
    .miso    (mosi16)
  );

  // Behavioural SPI slave and bus monitors, sampled on the falling clk edge.
  logic [31:0] slave_word = 32'h0;
  logic [31:0] s_cap      = 32'h0;
  logic        s_miso     = 1'b0;
  int          s_idx      = 0;
  int          cyc = 0, cs_low = 0, rises = 0, dones = 0, falls = 0;
  int          hi_run = 0, last_gap = 0;
  logic        sck_q = 1'b0, cs_q = 1'b1;
  int          cs16_low = 0, rises16 = 0, last_rise16 = -1;
  int          per16_min = 1000, per16_max = 0;
  logic        sck16_q = 1'b0, cs16_q = 1'b1;

  assign miso = loop ? mosi : s_miso;

  always @(negedge clk) begin
    cyc++;
    if (done) dones++;
    if (cs_n === 1'b1) begin
      hi_run++;
    end else begin
      cs_low++;
      if (cs_q) begin
        falls++;
        last_gap = hi_run;
        s_idx    = 0;
        s_cap    = 32'h0;
        s_miso   = slave_word[31];
      end
      hi_run = 0;
    end
    if (sck && !sck_q) begin
      rises++;
      s_cap = {s_cap[30:0], mosi};
    end
    if (!sck && sck_q) begin
      s_idx++;
      if (s_idx < 32) s_miso = slave_word[31-s_idx];
    end
    sck_q = sck;
    cs_q  = cs_n;

    if (cs16 === 1'b0) begin
      cs16_low++;
      if (cs16_q) begin
        last_rise16 = -1;
        per16_min   = 1000;
        per16_max   = 0;
      end
    end
    if (sck16 && !sck16_q) begin
      rises16++;
      if (last_rise16 >= 0) begin
        if (cyc - last_rise16 < per16_min) per16_min = cyc - last_rise16;
        if (cyc - last_rise16 > per16_max) per16_max = cyc - last_rise16;
      end
      last_rise16 = cyc;
    end
    sck16_q = sck16;
    cs16_q  = cs16;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame results filled in by run_frame.
  int lat, d_cs, d_rise, d_done, d_fall;

  // One frame on the 32-bit master; returns latency start->done and deltas.
  task automatic run_frame(input logic [31:0] tx);
    int b_cs, b_r, b_d, b_f;
    @(negedge clk);
    #1;
    b_cs = cs_low; b_r = rises; b_d = dones; b_f = falls;
    tx_data = tx;
    start   = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 2000) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (done) break;
    end
    #1;
    d_cs   = cs_low - b_cs;
    d_rise = rises - b_r;
    d_done = dones - b_d;
    d_fall = falls - b_f;
  endtask

  // Frame timing the reference derives from the protocol definition.
  localparam int EXP_LOW = (2 * 32 + 2) * 4;

  initial begin
    logic [31:0] w, sw;
    int b_d, b_f, n;

    reset = 1'b1; start = 1'b0; tx_data = 32'h0; loop = 1'b1;
    start16 = 1'b0; tx16 = 16'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs_n",    64'(cs_n),    64'd1);
    check("rst_sck",     64'(sck),     64'd0);
    check("rst_mosi",    64'(mosi),    64'd0);
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_done",    64'(done),    64'd0);
    check("rst_rx_data", 64'(rx_data), 64'd0);
    reset = 1'b0;

    // Loopback directed frame.
    loop = 1'b1;
    run_frame(32'hA5C3_0F96);
    check("lb_latency", 64'(lat),     64'(EXP_LOW + 1));
    check("lb_rx",      64'(rx_data), 64'h0000_0000_A5C3_0F96);
    check("lb_cs_low",  64'(d_cs),    64'(EXP_LOW));
    check("lb_rises",   64'(d_rise),  64'd32);
    check("lb_dones",   64'(d_done),  64'd1);
    @(negedge clk);
    check("lb_done_pulse", 64'(done), 64'd0);
    check("lb_busy_idle",  64'(busy), 64'd0);

    // Behavioural slave returning a fixed word.
    loop = 1'b0;
    slave_word = 32'h8000_1234;
    run_frame(32'h0000_00FF);
    check("sl_rx",  64'(rx_data), 64'h0000_0000_8000_1234);
    check("sl_cap", 64'(s_cap),   64'h0000_0000_0000_00FF);

    // Randomized slave and loopback frames.
    for (int i = 0; i < 4; i++) begin
      w  = $urandom;
      sw = $urandom;
      loop = 1'b0;
      slave_word = sw;
      run_frame(w);
      check("rnd_sl_rx",  64'(rx_data), 64'(sw));
      check("rnd_sl_cap", 64'(s_cap),   64'(w));
      check("rnd_sl_lat", 64'(lat),     64'(EXP_LOW + 1));
      loop = 1'b1;
      w = $urandom;
      run_frame(w);
      check("rnd_lb_rx",    64'(rx_data), 64'(w));
      check("rnd_lb_rises", 64'(d_rise),  64'd32);
    end

    // start held high for 600 cycles: two complete frames and a third running.
    loop = 1'b1;
    w = $urandom;
    @(negedge clk);
    #1;
    b_d = dones; b_f = falls;
    tx_data = w;
    start   = 1'b1;
    repeat (600) @(negedge clk);
    #1;
    check("cont_frames", 64'(falls - b_f), 64'd3);
    check("cont_dones",  64'(dones - b_d), 64'd2);
    check("cont_gap",    64'(last_gap),    64'd1);
    check("cont_busy",   64'(busy),        64'd1);
    check("cont_rx",     64'(rx_data),     64'(w));
    start = 1'b0;
    n = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("cont_third_done", 64'(done), 64'd1);

    // Reset after the 10th sck rise.
    run_frame(32'h5555_AAAA);
    @(negedge clk);
    #1;
    b_d = dones;
    n   = rises;
    tx_data = 32'hDEAD_BEEF;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (rises - n < 10 && cyc < 90000) begin
      @(negedge clk);
      #1;
    end
    check("rst10_reached", 64'(rises - n), 64'd10);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    check("rst10_cs_n", 64'(cs_n),    64'd1);
    check("rst10_sck",  64'(sck),     64'd0);
    check("rst10_mosi", 64'(mosi),    64'd0);
    check("rst10_busy", 64'(busy),    64'd0);
    check("rst10_rx",   64'(rx_data), 64'd0);
    repeat (300) @(negedge clk);
    #1;
    check("rst10_no_done", 64'(dones - b_d), 64'd0);
    run_frame(32'h1234_5678);
    check("rst10_next_rx", 64'(rx_data), 64'h0000_0000_1234_5678);

    // tx_data change and start pulse during a frame are ignored.
    @(negedge clk);
    #1;
    b_d = dones; b_f = falls;
    tx_data = 32'h0F0F_0F0F;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    tx_data = 32'hFFFF_FFFF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("ign_rx",  64'(rx_data), 64'h0000_0000_0F0F_0F0F);
    repeat (300) @(negedge clk);
    #1;
    check("ign_frames", 64'(falls - b_f), 64'd1);
    check("ign_dones",  64'(dones - b_d), 64'd1);

    // 16-bit master at CLK_DIV=1.
    @(negedge clk);
    #1;
    b_d = cs16_low; b_f = rises16;
    tx16    = 16'hBEEF;
    start16 = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      n++;
      start16 = 1'b0;
      if (done16) break;
    end
    #1;
    check("d1_latency", 64'(n),             64'd35);
    check("d1_cs_low",  64'(cs16_low - b_d), 64'd34);
    check("d1_rises",   64'(rises16 - b_f),  64'd16);
    check("d1_per_min", 64'(per16_min),      64'd2);
    check("d1_per_max", 64'(per16_max),      64'd2);
    check("d1_rx",      64'(rx16),           64'h0000_0000_0000_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
